// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready write port into a circular FIFO, LSB-first framing with optional parity.
// Start bit leaves 1 cycle after a word lands in an empty FIFO; s_ready drops while FIFO_DEPTH words are queued.
module uart_tx_buffered #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          rs232_tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic                 fifo_nempty;
  logic [DATA_BITS-1:0] fifo_dat;

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 baud_end;
  logic                 last_data;
  logic                 last_stop;
  logic                 frame_end;

  assign s_ready     = (count != CW'(FIFO_DEPTH));
  assign fifo_count  = count;
  assign fifo_nempty = (count != '0);
  assign fifo_dat    = mem[rd_ptr];
  assign push        = s_valid && s_ready;

  assign baud_end  = (baud_cnt == CNT_W'(DIV - 1));
  assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
  assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));
  assign frame_end = (state == STOP) && baud_end && last_stop;
  // Pop on an idle edge or on the last edge of a frame, so frames run back to back.
  assign pop       = fifo_nempty && ((state == IDLE) || frame_end);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if ((state == IDLE) || baud_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      rs232_tx <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= frame_end;
      if (pop) begin
        shreg    <= fifo_dat;
        par_bit  <= (^fifo_dat) ^ (PARITY == 2);
        bit_idx  <= '0;
        rs232_tx <= 1'b0;
        state    <= START;
      end else begin
        case (state)
          IDLE: begin
            rs232_tx <= 1'b1;
          end
          START: begin
            if (baud_end) begin
              rs232_tx <= shreg[0];
              shreg    <= shreg >> 1;
              bit_idx  <= '0;
              state    <= DATA;
            end
          end
          DATA: begin
            if (baud_end) begin
              if (last_data) begin
                bit_idx <= '0;
                if (PARITY != 0) begin
                  rs232_tx <= par_bit;
                  state    <= PAR;
                end else begin
                  rs232_tx <= 1'b1;
                  state    <= STOP;
                end
              end else begin
                rs232_tx <= shreg[0];
                shreg    <= shreg >> 1;
                bit_idx  <= bit_idx + IDX_W'(1);
              end
            end
          end
          PAR: begin
            if (baud_end) begin
              rs232_tx <= 1'b1;
              bit_idx  <= '0;
              state    <= STOP;
            end
          end
          STOP: begin
            if (baud_end) begin
              if (last_stop) begin
                state <= IDLE;
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end
          default: begin
            rs232_tx <= 1'b1;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four configurations at DIV=4 (8N1, 8E1, 8O1, 7N2) against a queue-level line model.
module tb_uart_tx_buffered;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_valid;
  logic [3:0] s_ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;
  logic [7:0] s_data [4];
  logic [2:0] cnt [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_HZ(50_000_000), .BAUD(12_500_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
    .rs232_tx(tx[0]), .busy(busy[0]), .tx_done(done[0]), .fifo_count(cnt[0]));
  uart_tx_buffered #(.CLK_HZ(50_000_000), .BAUD(12_500_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
    .rs232_tx(tx[1]), .busy(busy[1]), .tx_done(done[1]), .fifo_count(cnt[1]));
  uart_tx_buffered #(.CLK_HZ(50_000_000), .BAUD(12_500_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[2]), .s_data(s_data[2]), .s_ready(s_ready[2]),
    .rs232_tx(tx[2]), .busy(busy[2]), .tx_done(done[2]), .fifo_count(cnt[2]));
  uart_tx_buffered #(.CLK_HZ(50_000_000), .BAUD(12_500_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7n2 (
    .clk(clk), .rst(rst), .s_valid(s_valid[3]), .s_data(s_data[3][6:0]), .s_ready(s_ready[3]),
    .rs232_tx(tx[3]), .busy(busy[3]), .tx_done(done[3]), .fifo_count(cnt[3]));

  // Reference model state for the DUT currently under test.
  int         cur_k;
  int         t;
  int         avail;
  int         cur_start;
  logic [7:0] cur_data;
  logic [7:0] mq [$];
  logic       last_push;
  int         last_start_t;
  int         last_done_t;
  int         done_cnt;
  int         busy_cnt;

  function automatic int dbits(input int k);
    return (k == 3) ? 7 : 8;
  endfunction

  function automatic int pmode(input int k);
    return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
  endfunction

  function automatic int sbits(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return DIV * (1 + dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k));
  endfunction

  function automatic logic [7:0] dmask(input int k);
    return (k == 3) ? 8'h7F : 8'hFF;
  endfunction

  // Frame bit b: start, data LSB first, optional parity, then stop bits.
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int b);
    logic p;
    if (b == 0) return 1'b0;
    if (b <= dbits(k)) return d[b-1];
    if (pmode(k) != 0 && b == dbits(k) + 1) begin
      p = 1'b0;
      for (int i = 0; i < dbits(k); i++) p = p ^ d[i];
      return (pmode(k) == 2) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at t=%0d", tag, obs, exp_v, t);
    end
  endtask

  task automatic tick();
    logic       v;
    logic [7:0] d;
    int         pre;
    logic       dn;
    logic       pop_n;
    logic       exp_tx;
    v = s_valid[cur_k];
    d = s_data[cur_k] & dmask(cur_k);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      cur_start = -1;
      avail     = 0;
      last_push = 1'b0;
      t++;
      #1;
      for (int k = 0; k < 4; k++) begin
        chk("rst_tx", tx[k], 1);
        chk("rst_busy", busy[k], 0);
        chk("rst_done", done[k], 0);
        chk("rst_count", cnt[k], 0);
        chk("rst_ready", s_ready[k], 1);
      end
      return;
    end
    pre = mq.size();
    dn  = (cur_start >= 0) && (t == cur_start + flen(cur_k));
    if (dn) cur_start = -1;
    pop_n = (pre > 0) && (t >= avail);
    if (pop_n) begin
      cur_data     = mq.pop_front();
      cur_start    = t;
      avail        = t + flen(cur_k);
      last_start_t = t;
    end
    last_push = v && (pre != DEPTH);
    if (last_push) mq.push_back(d);
    exp_tx = (cur_start >= 0) ? exp_bit(cur_k, cur_data, (t - cur_start) / DIV) : 1'b1;
    #1;
    if (done[cur_k] === 1'b1) begin
      done_cnt++;
      last_done_t = t;
    end
    if (busy[cur_k] === 1'b1) busy_cnt++;
    chk("s_ready", s_ready[cur_k], (mq.size() != DEPTH));
    chk("fifo_count", cnt[cur_k], mq.size());
    chk("tx_done", done[cur_k], dn);
    chk("busy", busy[cur_k], (cur_start >= 0));
    chk("rs232_tx", tx[cur_k], exp_tx);
    t++;
  endtask

  task automatic push_word(input logic [7:0] d);
    s_data[cur_k]  = d;
    s_valid[cur_k] = 1'b1;
    tick();
    s_valid[cur_k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() > 0 || cur_start >= 0) && n < 3000) begin
      tick();
      n++;
    end
    tick();
    chk("drain_idle", busy[cur_k], 0);
  endtask

  initial begin
    logic [7:0] directed [4];
    int         flen_req [4];
    int         n;
    int         guard;
    directed = '{8'h55, 8'h07, 8'h07, 8'h41};
    flen_req = '{40, 44, 44, 40};
    rst       = 1'b1;
    s_valid   = 4'hF;
    for (int k = 0; k < 4; k++) s_data[k] = 8'($urandom);
    cur_k     = 0;
    t         = 0;
    avail     = 0;
    cur_start = -1;
    last_push = 1'b0;
    done_cnt  = 0;
    busy_cnt  = 0;
    last_start_t = 0;
    last_done_t  = 0;

    repeat (3) tick();
    rst     = 1'b0;
    s_valid = 4'h0;
    tick();

    for (int k = 0; k < 4; k++) begin
      cur_k = k;
      push_word(directed[k]);
      drain();
      chk("frame_len", last_done_t - last_start_t, flen_req[k]);
      repeat (24) begin
        s_valid[cur_k] = 1'($urandom_range(0, 1));
        s_data[cur_k]  = 8'($urandom);
        tick();
      end
      s_valid[cur_k] = 1'b0;
      drain();
    end

    // Back-to-back: words 1..6 offered continuously on the 8N1 instance.
    cur_k      = 0;
    done_cnt   = 0;
    busy_cnt   = 0;
    n          = 1;
    s_data[0]  = 8'd1;
    s_valid[0] = 1'b1;
    guard      = 0;
    while (n <= 6 && guard < 400) begin
      tick();
      guard++;
      if (last_push) begin
        n++;
        s_data[0] = 8'(n);
      end
    end
    s_valid[0] = 1'b0;
    chk("b2b_all_accepted", n, 7);
    drain();
    chk("b2b_done_pulses", done_cnt, 6);
    chk("b2b_busy_cycles", busy_cnt, 6 * 40);

    // Reset during data bit 3 with two words still queued.
    s_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data[0] = 8'($urandom);
      tick();
    end
    s_valid[0] = 1'b0;
    guard = 0;
    while (!(cur_start >= 0 && (t - 1 - cur_start) == DIV * 4 + 1) && guard < 100) begin
      tick();
      guard++;
    end
    chk("pre_rst_count", cnt[0], 2);
    chk("pre_rst_busy", busy[0], 1);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx[0], 1);
    chk("async_rst_count", cnt[0], 0);
    chk("async_rst_busy", busy[0], 0);
    repeat (2) tick();
    rst      = 1'b0;
    done_cnt = 0;
    repeat (100) tick();
    chk("post_rst_no_done", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
